mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/utils_pkg.sv | 32 +++
 rtl/arb_id_fifo.sv | 58 +++++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// Shared request/response payloads and requester IDs for the memory arbiter.
package utils_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic {
    ARB_ID_FETCH = 1'b0,
    ARB_ID_LSU   = 1'b1
  } arb_id_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } s_arb_req_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } s_arb_rsp_t;

  // Pointer width that never collapses to zero bits for a depth of 1.
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered memory requests.
module arb_id_fifo
  import utils_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  arb_id_t push_id,
  input  logic    pop,
  output arb_id_t pop_id,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  arb_id_t            entries_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push && (!full || pop_ok);
  assign pop_id  = entries_q[rd_ptr_q];

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_ok) entries_q[wr_ptr_q] <= push_id;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/LSU) arbiter for a single memory port with in-order response routing.
// Optional fetch anti-starvation promotion enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_arbiter
  import utils_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  s_arb_req_t fetch_req_i,
  output logic       fetch_ready_o,
  input  s_arb_req_t lsu_req_i,
  output logic       lsu_ready_o,
  output s_arb_req_t mem_req_o,
  input  logic       mem_ready_i,
  input  s_arb_rsp_t mem_rsp_i,
  output s_arb_rsp_t fetch_rsp_o,
  output s_arb_rsp_t lsu_rsp_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_LOCK_FETCH = 2'd1;
  localparam logic [1:0] ST_LOCK_LSU   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] outstanding_q;
  logic             gnt_valid;
  arb_id_t          gnt_id;
  logic             offer;
  logic             accept;
  logic             slot_avail;
  logic             rsp_pop;
  logic             promote_fetch;
  arb_id_t          fifo_pop_id;
  logic             fifo_full;
  logic             fifo_empty;

  // Responses with nothing outstanding are dropped, never routed.
  assign rsp_pop    = mem_rsp_i.valid && !fifo_empty;
  assign slot_avail = rst && ((!fifo_full && (outstanding_q < CNT_W'(MAX_OUTSTANDING))) || rsp_pop);

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_q;
  logic                fetch_accept;

  assign fetch_accept  = accept && (gnt_id == ARB_ID_FETCH);
  assign promote_fetch = (starve_q >= STARVE_W'(STARVE_LIMIT));

  // Saturating count of cycles fetch waited without being accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (fetch_accept) begin
      starve_q <= '0;
    end else if (fetch_req_i.valid && (starve_q < STARVE_W'(STARVE_LIMIT))) begin
      starve_q <= starve_q + STARVE_W'(1);
    end
  end
`else
  assign promote_fetch = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Arbitration, request mux, ready generation and lock next-state.
  always_comb begin
    gnt_valid     = 1'b0;
    gnt_id        = ARB_ID_FETCH;
    offer         = 1'b0;
    accept        = 1'b0;
    mem_req_o     = '0;
    fetch_ready_o = 1'b0;
    lsu_ready_o   = 1'b0;
    state_d       = ST_IDLE;

    if ((state_q == ST_LOCK_FETCH) && fetch_req_i.valid) begin
      gnt_valid = 1'b1;
      gnt_id    = ARB_ID_FETCH;
    end else if ((state_q == ST_LOCK_LSU) && lsu_req_i.valid) begin
      gnt_valid = 1'b1;
      gnt_id    = ARB_ID_LSU;
    end else if (promote_fetch && fetch_req_i.valid) begin
      gnt_valid = 1'b1;
      gnt_id    = ARB_ID_FETCH;
    end else if (lsu_req_i.valid) begin
      gnt_valid = 1'b1;
      gnt_id    = ARB_ID_LSU;
    end else if (fetch_req_i.valid) begin
      gnt_valid = 1'b1;
      gnt_id    = ARB_ID_FETCH;
    end

    offer  = gnt_valid && slot_avail;
    accept = offer && mem_ready_i;

    if (offer) mem_req_o = (gnt_id == ARB_ID_LSU) ? lsu_req_i : fetch_req_i;
    fetch_ready_o = accept && (gnt_id == ARB_ID_FETCH);
    lsu_ready_o   = accept && (gnt_id == ARB_ID_LSU);

    // An offered-but-refused request owns the port until taken or withdrawn.
    if (offer && !mem_ready_i) begin
      state_d = (gnt_id == ARB_ID_LSU) ? ST_LOCK_LSU : ST_LOCK_FETCH;
    end else if (!accept) begin
      case (state_q)
        ST_LOCK_FETCH: state_d = fetch_req_i.valid ? ST_LOCK_FETCH : ST_IDLE;
        ST_LOCK_LSU:   state_d = lsu_req_i.valid ? ST_LOCK_LSU : ST_IDLE;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding_q <= '0;
    end else begin
      case ({accept, rsp_pop})
        2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (gnt_id),
    .pop     (rsp_pop),
    .pop_id  (fifo_pop_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Data is shared by both sides; only the owner of the oldest request sees valid.
  always_comb begin
    fetch_rsp_o = '0;
    lsu_rsp_o   = '0;
    if (rsp_pop) begin
      fetch_rsp_o.rdata = mem_rsp_i.rdata;
      fetch_rsp_o.err   = mem_rsp_i.err;
      lsu_rsp_o.rdata   = mem_rsp_i.rdata;
      lsu_rsp_o.err     = mem_rsp_i.err;
      fetch_rsp_o.valid = (fifo_pop_id == ARB_ID_FETCH);
      lsu_rsp_o.valid   = (fifo_pop_id == ARB_ID_LSU);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand sequences, random vs. model.
module tb_mem_arbiter;
  import utils_pkg::*;

  localparam int unsigned MAX_OUT = 2;
  localparam int unsigned STARVE  = 4;

  logic       clk = 1'b0;
  logic       rst;
  s_arb_req_t fetch_req, lsu_req, mem_req;
  logic       fetch_ready, lsu_ready, mem_ready;
  s_arb_rsp_t mem_rsp, fetch_rsp, lsu_rsp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .MAX_OUTSTANDING (MAX_OUT),
    .STARVE_LIMIT    (STARVE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_req_i   (fetch_req),
    .fetch_ready_o (fetch_ready),
    .lsu_req_i     (lsu_req),
    .lsu_ready_o   (lsu_ready),
    .mem_req_o     (mem_req),
    .mem_ready_i   (mem_ready),
    .mem_rsp_i     (mem_rsp),
    .fetch_rsp_o   (fetch_rsp),
    .lsu_rsp_o     (lsu_rsp)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic s_arb_req_t mk(input logic v, input logic is_lsu);
    s_arb_req_t r;
    r = '0;
    if (v) begin
      r.valid = 1'b1;
      if (is_lsu) begin
        r.addr = 32'h0000_2000; r.we = 1'b1; r.wdata = 32'hdead_beef; r.be = 4'h3;
      end else begin
        r.addr = 32'h0000_1000; r.be = 4'hf;
      end
    end
    return r;
  endfunction

  task automatic drive(input logic fv, input logic lv, input logic mr, input logic rv, input logic [31:0] rd);
    fetch_req = mk(fv, 1'b0);
    lsu_req   = mk(lv, 1'b1);
    mem_ready = mr;
    mem_rsp   = '{valid: rv, rdata: rd, err: rd[0]};
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic fv, lv, mr, rv;
    logic mv;
    int   gnt;   // 0 none, 1 fetch, 2 lsu
    logic fr, lr, frv, lrv;
  } vec_t;

  vec_t vecs [21];

  // Reference model state.
  logic q[$];
  logic owed_valid;
  logic owed_id;
  int   wait_cnt;
  logic f_pend, l_pend;

  initial begin
    s_arb_req_t exp_req, exp_rsp_f, exp_rsp_l;
    logic [31:0] exp_addr;
    logic pop_ok, avail, g, gid, starved, exp_mv, acc, exp_l;

    // fv lv mr rv | mv gnt fr lr frv lrv
    vecs[0]  = '{1,1,1,0, 1,2,0,1,0,0};
    vecs[1]  = '{1,0,1,0, 1,1,1,0,0,0};
    vecs[2]  = '{0,0,1,1, 0,0,0,0,0,1};
    vecs[3]  = '{0,0,1,1, 0,0,0,0,1,0};
    vecs[4]  = '{1,0,0,0, 1,1,0,0,0,0};
    vecs[5]  = '{1,1,0,0, 1,1,0,0,0,0};
    vecs[6]  = '{1,1,0,0, 1,1,0,0,0,0};
    vecs[7]  = '{1,1,1,0, 1,1,1,0,0,0};
    vecs[8]  = '{0,1,1,0, 1,2,0,1,0,0};
    vecs[9]  = '{1,1,1,0, 0,0,0,0,0,0};
    vecs[10] = '{1,1,1,1, 1,2,0,1,1,0};
    vecs[11] = '{1,0,1,0, 0,0,0,0,0,0};
    vecs[12] = '{1,0,0,1, 1,1,0,0,0,1};
    vecs[13] = '{1,1,1,1, 1,1,1,0,0,1};
    vecs[14] = '{0,0,1,1, 0,0,0,0,1,0};
    vecs[15] = '{0,0,1,1, 0,0,0,0,0,0};
    vecs[16] = '{0,1,1,0, 1,2,0,1,0,0};
    vecs[17] = '{0,1,1,0, 1,2,0,1,0,0};
    vecs[18] = '{0,1,1,0, 0,0,0,0,0,0};
    vecs[19] = '{0,0,1,1, 0,0,0,0,0,1};
    vecs[20] = '{0,0,1,1, 0,0,0,0,0,1};

    // Reset with both requesters valid: everything must stay quiet.
    rst = 1'b0;
    drive(1, 1, 1, 1, 32'h1);
    @(negedge clk);
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_fetch_ready", 128'(fetch_ready), 128'(0));
    chk("rst_lsu_ready", 128'(lsu_ready), 128'(0));
    chk("rst_fetch_rsp", 128'(fetch_rsp), 128'(0));
    chk("rst_lsu_rsp", 128'(lsu_rsp), 128'(0));
    next_cyc();
    drive(0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    next_cyc();

    // Directed vector table.
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].fv, vecs[i].lv, vecs[i].mr, vecs[i].rv, 32'h5000 + 32'(i));
      @(negedge clk);
      exp_addr = (vecs[i].gnt == 2) ? 32'h2000 : (vecs[i].gnt == 1) ? 32'h1000 : 32'h0;
      chk($sformatf("vec%0d_mem_valid", i), 128'(mem_req.valid), 128'(vecs[i].mv));
      chk($sformatf("vec%0d_mem_addr", i), 128'(mem_req.addr), 128'(exp_addr));
      chk($sformatf("vec%0d_fetch_ready", i), 128'(fetch_ready), 128'(vecs[i].fr));
      chk($sformatf("vec%0d_lsu_ready", i), 128'(lsu_ready), 128'(vecs[i].lr));
      chk($sformatf("vec%0d_fetch_rsp_valid", i), 128'(fetch_rsp.valid), 128'(vecs[i].frv));
      chk($sformatf("vec%0d_lsu_rsp_valid", i), 128'(lsu_rsp.valid), 128'(vecs[i].lrv));
      if (vecs[i].frv || vecs[i].lrv) begin
        chk($sformatf("vec%0d_rsp_rdata", i),
            128'(vecs[i].frv ? fetch_rsp.rdata : lsu_rsp.rdata), 128'(32'h5000 + 32'(i)));
      end
      next_cyc();
    end

    // Reset with two requests outstanding; late responses must be dropped.
    for (int c = 0; c < 2; c++) begin
      drive(0, 1, 1, 0, 32'h0);
      @(negedge clk);
      chk("pre_rst_lsu_ready", 128'(lsu_ready), 128'(1));
      next_cyc();
    end
    rst = 1'b0;
    drive(1, 1, 1, 1, 32'h77);
    @(negedge clk);
    chk("mid_rst_mem_req", 128'(mem_req), 128'(0));
    chk("mid_rst_readies", 128'({fetch_ready, lsu_ready}), 128'(0));
    next_cyc();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 1, 1, 32'h88 + 32'(c));
      @(negedge clk);
      chk("post_rst_fetch_rsp_valid", 128'(fetch_rsp.valid), 128'(0));
      chk("post_rst_lsu_rsp_valid", 128'(lsu_rsp.valid), 128'(0));
      next_cyc();
    end
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 1, 0, 32'h0);
      @(negedge clk);
      chk("post_rst_slot_ready", 128'(lsu_ready), 128'(c < 2));
      next_cyc();
    end
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 1, 1, 32'h99);
      @(negedge clk);
      chk("post_rst_drain_lsu_rsp", 128'(lsu_rsp.valid), 128'(1));
      next_cyc();
    end

    // Fairness: both valid every cycle, memory always ready.
    rst = 1'b0;
    next_cyc();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(1, 1, 1, (c > 0), 32'h0);
      @(negedge clk);
`ifdef MEM_ARB_FAIRNESS_EN
      exp_l = (c != 4);
`else
      exp_l = 1'b1;
`endif
      chk($sformatf("fair%0d_lsu_ready", c), 128'(lsu_ready), 128'(exp_l));
      chk($sformatf("fair%0d_fetch_ready", c), 128'(fetch_ready), 128'(!exp_l));
      next_cyc();
    end

    // Randomized traffic against the queue-based reference model.
    rst = 1'b0;
    drive(0, 0, 0, 0, 32'h0);
    next_cyc();
    rst = 1'b1;
    q.delete();
    owed_valid = 1'b0; owed_id = 1'b0; wait_cnt = 0;
    f_pend = 1'b0; l_pend = 1'b0;
    fetch_req = '0; lsu_req = '0;
    for (int c = 0; c < 2000; c++) begin
      if (!f_pend && ($urandom_range(0, 99) < 55)) begin
        f_pend = 1'b1;
        fetch_req = '{valid: 1'b1, addr: $urandom, we: 1'b0, wdata: 32'h0, be: 4'hf};
      end
      if (!l_pend && ($urandom_range(0, 99) < 55)) begin
        l_pend = 1'b1;
        lsu_req = '{valid: 1'b1, addr: $urandom, we: 1'($urandom), wdata: $urandom, be: 4'($urandom)};
      end
      if (!f_pend) fetch_req = '0;
      if (!l_pend) lsu_req = '0;
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rsp   = '{valid: ($urandom_range(0, 2) == 0), rdata: $urandom, err: 1'($urandom)};
      @(negedge clk);

      pop_ok = mem_rsp.valid && (q.size() > 0);
      avail  = (q.size() < MAX_OUT) || pop_ok;
`ifdef MEM_ARB_FAIRNESS_EN
      starved = (wait_cnt >= STARVE);
`else
      starved = 1'b0;
`endif
      g = 1'b1; gid = 1'b0;
      if (owed_valid && (owed_id ? l_pend : f_pend)) gid = owed_id;
      else if (starved && f_pend) gid = 1'b0;
      else if (l_pend)            gid = 1'b1;
      else if (f_pend)            gid = 1'b0;
      else                        g = 1'b0;
      exp_mv  = g && avail;
      exp_req = exp_mv ? (gid ? lsu_req : fetch_req) : '0;
      acc     = exp_mv && mem_ready;
      exp_rsp_f = '0; exp_rsp_l = '0;
      if (pop_ok) begin
        if (q[0]) exp_rsp_l = '{valid: 1'b1, addr: '0, we: 1'b0, wdata: '0, be: '0};
        else      exp_rsp_f = '{valid: 1'b1, addr: '0, we: 1'b0, wdata: '0, be: '0};
      end

      chk("rand_mem_req", 128'(mem_req), 128'(exp_req));
      chk("rand_fetch_ready", 128'(fetch_ready), 128'(acc && !gid));
      chk("rand_lsu_ready", 128'(lsu_ready), 128'(acc && gid));
      chk("rand_fetch_rsp_valid", 128'(fetch_rsp.valid), 128'(exp_rsp_f.valid));
      chk("rand_lsu_rsp_valid", 128'(lsu_rsp.valid), 128'(exp_rsp_l.valid));
      if (pop_ok) begin
        chk("rand_rsp_data", 128'({fetch_rsp.rdata, fetch_rsp.err, lsu_rsp.rdata, lsu_rsp.err}),
            128'({mem_rsp.rdata, mem_rsp.err, mem_rsp.rdata, mem_rsp.err}));
      end

      if (pop_ok) void'(q.pop_front());
      if (acc) q.push_back(gid);
      if (exp_mv && !mem_ready) begin
        owed_valid = 1'b1; owed_id = gid;
      end else if (acc || !(owed_id ? l_pend : f_pend)) begin
        owed_valid = 1'b0;
      end
      if (acc && !gid) wait_cnt = 0;
      else if (f_pend && wait_cnt < STARVE) wait_cnt++;
      if (acc && !gid) f_pend = 1'b0;
      if (acc && gid)  l_pend = 1'b0;
      next_cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
